load_store_unit: RTL and testbench

Byte-addressed load/store front end between the CPU execute/memory stage and the word-addressed data_mem (11-bit word address, 32-bit data, single we, no byte enables).
- Converts lb/lh/lw/lbu/lhu/sb/sh/sw requests into data_mem word accesses.
- Sub-word stores use read-modify-write.
- Loads return lane-extracted, sign/zero-extended data.
- Misaligned and illegal accesses are flagged; they never touch memory.

---
 rtl/lsu_pkg.sv | 26 ++
 rtl/lsu_lane_align.sv | 43 ++++
 rtl/load_store_unit.sv | 149 ++++++++++++++
 tb/tb_load_store_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
package lsu_pkg;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;
   localparam logic [1:0] SIZE_X = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      WAIT,
      WRITE,
      ERR
   } state_t;

   function automatic logic bad_access(
      input logic [1:0] size,
      input logic [1:0] lane
   );
      return (size == SIZE_X)
         || (size == SIZE_H && lane[0])
         || (size == SIZE_W && lane != 2'b00);
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane extraction for loads and
// lane merge for read-modify-write stores.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   input  logic [1:0]  lane,
   input  logic [1:0]  size,
   input  logic        uns,
   output logic [31:0] rdata,
   output logic [31:0] merged
);

   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      b = word[8*lane +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      rdata = '0;
      merged = word;
      case (size)
         SIZE_B: begin
            rdata = {{24{~uns & b[7]}}, b};
            merged[8*lane +: 8] = wdata[7:0];
         end
         SIZE_H: begin
            rdata = {{16{~uns & h[15]}}, h};
            if (lane[1])
               merged[31:16] = wdata[15:0];
            else
               merged[15:0] = wdata[15:0];
         end
         SIZE_W: begin
            rdata = word;
            merged = wdata;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a
// word-addressed data memory without byte enables.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 11,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   state_t state, state_n;

   logic        r_we;
   logic [1:0]  r_size;
   logic        r_uns;
   logic [1:0]  r_lane;
   logic [31:0] r_wdata;

   logic              mem_we_n;
   logic [ADDR_W-1:0] mem_addr_n;
   logic [31:0]       mem_wdata_n;

   logic        accept;
   logic        data_ph;
   logic [31:0] ext;
   logic [31:0] merged;

   // Upper address bits wrap and are intentionally dropped.
   logic unused_addr;
   assign unused_addr = ^req_addr[31:ADDR_W+2];

   assign req_ready = (state == IDLE);
   assign accept = req_valid & req_ready;

   // Cycle in which mem_rdata holds the addressed word.
   assign data_ph = (state == WAIT)
      || (state == READ && RD_LAT == 0);

   lsu_lane_align u_align (
      .word   (mem_rdata),
      .wdata  (r_wdata),
      .lane   (r_lane),
      .size   (r_size),
      .uns    (r_uns),
      .rdata  (ext),
      .merged (merged)
   );

   always_comb begin
      state_n = state;
      mem_we_n = 1'b0;
      mem_addr_n = mem_addr;
      mem_wdata_n = mem_wdata;
      resp_valid = 1'b0;
      resp_err = 1'b0;
      resp_rdata = '0;
      unique case (state)
         IDLE: begin
            if (req_valid) begin
               if (bad_access(req_size, req_addr[1:0])) begin
                  state_n = ERR;
               end else begin
                  mem_addr_n = req_addr[ADDR_W+1:2];
                  if (req_we && req_size == SIZE_W) begin
                     state_n = WRITE;
                     mem_we_n = 1'b1;
                     mem_wdata_n = req_wdata;
                  end else begin
                     state_n = READ;
                  end
               end
            end
         end
         READ: begin
            if (!data_ph)
               state_n = WAIT;
         end
         WAIT: ;
         WRITE: begin
            resp_valid = 1'b1;
            state_n = IDLE;
         end
         ERR: begin
            resp_valid = 1'b1;
            resp_err = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      if (data_ph) begin
         if (r_we) begin
            state_n = WRITE;
            mem_we_n = 1'b1;
            mem_wdata_n = merged;
         end else begin
            resp_valid = 1'b1;
            resp_rdata = ext;
            state_n = IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         mem_we <= 1'b0;
         mem_addr <= '0;
         mem_wdata <= '0;
      end else begin
         state <= state_n;
         mem_we <= mem_we_n;
         mem_addr <= mem_addr_n;
         mem_wdata <= mem_wdata_n;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we <= 1'b0;
         r_size <= SIZE_B;
         r_uns <= 1'b0;
         r_lane <= 2'b00;
         r_wdata <= '0;
      end else if (accept) begin
         r_we <= req_we;
         r_size <= req_size;
         r_uns <= req_unsigned;
         r_lane <= req_addr[1:0];
         r_wdata <= req_wdata;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: two LSUs, RD_LAT=0 (index 0) and
// RD_LAT=1 (index 1), each with its own data_mem model.
module tb_load_store_unit;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      int          lat1;
      int          lat0;
      int          nwe;
      logic [31:0] mwd;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        rv   [2];
   logic        rdy  [2];
   logic        rwe  [2];
   logic [1:0]  rsz  [2];
   logic        runs [2];
   logic [31:0] radr [2];
   logic [31:0] rwd  [2];
   logic        rsv  [2];
   logic [31:0] rdat [2];
   logic        rerr [2];
   logic        mwe  [2];
   logic [10:0] madr [2];
   logic [31:0] mwd  [2];
   logic [31:0] mrd0, mrd1;

   logic [31:0] m0 [0:2047];
   logic [31:0] m1 [0:2047];

   int passed = 0;
   int total = 0;

   load_store_unit #(.ADDR_W(11), .RD_LAT(0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(rv[0]), .req_ready(rdy[0]),
      .req_we(rwe[0]), .req_size(rsz[0]),
      .req_unsigned(runs[0]), .req_addr(radr[0]),
      .req_wdata(rwd[0]), .resp_valid(rsv[0]),
      .resp_rdata(rdat[0]), .resp_err(rerr[0]),
      .mem_we(mwe[0]), .mem_addr(madr[0]),
      .mem_wdata(mwd[0]), .mem_rdata(mrd0)
   );

   load_store_unit #(.ADDR_W(11), .RD_LAT(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(rv[1]), .req_ready(rdy[1]),
      .req_we(rwe[1]), .req_size(rsz[1]),
      .req_unsigned(runs[1]), .req_addr(radr[1]),
      .req_wdata(rwd[1]), .resp_valid(rsv[1]),
      .resp_rdata(rdat[1]), .resp_err(rerr[1]),
      .mem_we(mwe[1]), .mem_addr(madr[1]),
      .mem_wdata(mwd[1]), .mem_rdata(mrd1)
   );

   assign mrd0 = m0[madr[0]];
   always @(posedge clk)
      if (mwe[0]) m0[madr[0]] <= mwd[0];

   always @(posedge clk) begin
      if (mwe[1]) m1[madr[1]] <= mwd[1];
      mrd1 <= m1[madr[1]];
   end

   task automatic chk(
      input string nm,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s got %h exp %h", nm, got, exp);
   endtask

   task automatic drive(input int u, input vec_t v);
      rwe[u] = v.we;
      rsz[u] = v.size;
      runs[u] = v.uns;
      radr[u] = v.addr;
      rwd[u] = v.wdata;
   endtask

   task automatic do_req(
      input  int          u,
      input  vec_t        v,
      input  string       nm,
      output logic [31:0] rd,
      output logic        er,
      output int          lat,
      output int          nwe,
      output int          nresp,
      output logic [31:0] wd,
      output logic [10:0] wa
   );
      @(negedge clk);
      drive(u, v);
      rv[u] = 1'b1;
      chk({nm, "_ready"}, 32'(rdy[u]), 32'd1);
      @(posedge clk);
      #1 rv[u] = 1'b0;
      lat = 0; nwe = 0; nresp = 0;
      rd = '0; er = 1'b0; wd = '0; wa = '0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (rsv[u]) begin
            nresp++;
            if (lat == 0) begin
               lat = k;
               rd = rdat[u];
               er = rerr[u];
            end
         end
         if (mwe[u]) begin
            nwe++;
            wd = mwd[u];
            wa = madr[u];
         end
      end
   endtask

   vec_t tbl [13];

   initial begin
      logic [31:0] rd, wd;
      logic [10:0] wa;
      logic        er;
      int          lat, nwe, nresp, nv, elat;
      logic [4:0]  rp, sp, wp;
      string       nm;
      vec_t        v;

      for (int i = 0; i < 2048; i++) begin
         m0[i] = '0;
         m1[i] = '0;
      end
      for (int u = 0; u < 2; u++) begin
         rv[u] = 1'b0;
         rwe[u] = 1'b0;
         rsz[u] = 2'b00;
         runs[u] = 1'b0;
         radr[u] = '0;
         rwd[u] = '0;
      end

      //          we size  un addr   wdata         rdata         er l1 l0 we mwd
      tbl[0]  = '{1, 2'b10, 0, 32'h4, 32'hDEADBEEF, 32'h0,        0, 1, 1, 1, 32'hDEADBEEF};
      tbl[1]  = '{0, 2'b10, 0, 32'h4, 32'h0,        32'hDEADBEEF, 0, 2, 1, 0, 32'h0};
      tbl[2]  = '{0, 2'b00, 0, 32'h7, 32'h0,        32'hFFFFFFDE, 0, 2, 1, 0, 32'h0};
      tbl[3]  = '{0, 2'b00, 1, 32'h7, 32'h0,        32'h000000DE, 0, 2, 1, 0, 32'h0};
      tbl[4]  = '{0, 2'b01, 0, 32'h6, 32'h0,        32'hFFFFDEAD, 0, 2, 1, 0, 32'h0};
      tbl[5]  = '{0, 2'b01, 1, 32'h4, 32'h0,        32'h0000BEEF, 0, 2, 1, 0, 32'h0};
      tbl[6]  = '{0, 2'b00, 0, 32'h4, 32'h0,        32'hFFFFFFEF, 0, 2, 1, 0, 32'h0};
      tbl[7]  = '{1, 2'b00, 0, 32'h5, 32'h12345655, 32'h0,        0, 3, 2, 1, 32'hDEAD55EF};
      tbl[8]  = '{1, 2'b01, 0, 32'h6, 32'h0000A5A5, 32'h0,        0, 3, 2, 1, 32'hA5A555EF};
      tbl[9]  = '{0, 2'b10, 0, 32'h4, 32'h0,        32'hA5A555EF, 0, 2, 1, 0, 32'h0};
      tbl[10] = '{0, 2'b10, 0, 32'h2, 32'h0,        32'h0,        1, 1, 1, 0, 32'h0};
      tbl[11] = '{1, 2'b01, 0, 32'h3, 32'h0,        32'h0,        1, 1, 1, 0, 32'h0};
      tbl[12] = '{0, 2'b11, 0, 32'h8, 32'h0,        32'h0,        1, 1, 1, 0, 32'h0};

      repeat (2) @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         nm = $sformatf("rst_u%0d", u);
         chk({nm, "_ready"}, 32'(rdy[u]), 32'd1);
         chk({nm, "_resp"}, 32'(rsv[u]), 32'd0);
         chk({nm, "_rdata"}, rdat[u], 32'd0);
         chk({nm, "_err"}, 32'(rerr[u]), 32'd0);
         chk({nm, "_we"}, 32'(mwe[u]), 32'd0);
         chk({nm, "_addr"}, 32'(madr[u]), 32'd0);
         chk({nm, "_wdata"}, mwd[u], 32'd0);
      end
      rst_n = 1'b1;

      for (int u = 1; u >= 0; u--) begin
         nv = (u == 1) ? 13 : 10;
         for (int i = 0; i < nv; i++) begin
            v = tbl[i];
            nm = $sformatf("v%0d_u%0d", i, u);
            elat = (u == 1) ? v.lat1 : v.lat0;
            do_req(u, v, nm, rd, er, lat, nwe, nresp, wd, wa);
            chk({nm, "_lat"}, 32'(lat), 32'(elat));
            chk({nm, "_nresp"}, 32'(nresp), 32'd1);
            chk({nm, "_err"}, 32'(er), 32'(v.err));
            chk({nm, "_rdata"}, rd, v.rdata);
            chk({nm, "_nwe"}, 32'(nwe), 32'(v.nwe));
            if (v.nwe != 0) begin
               chk({nm, "_mwd"}, wd, v.mwd);
               chk({nm, "_madr"}, 32'(wa), 32'd1);
            end
         end
      end

      // Back-to-back: lw 0x004 then sw 0x008 with valid held.
      @(negedge clk);
      v = tbl[1];
      drive(1, v);
      rv[1] = 1'b1;
      @(posedge clk);
      #1;
      v = '{1, 2'b10, 0, 32'h8, 32'h11223344,
            32'h0, 0, 1, 1, 1, 32'h0};
      drive(1, v);
      rp = '0; sp = '0; wp = '0; rd = '0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         rp[k-1] = rdy[1];
         sp[k-1] = rsv[1];
         wp[k-1] = mwe[1];
         if (k == 2) rd = rdat[1];
         @(posedge clk);
         #1;
         if (rp[k-1] && rv[1]) rv[1] = 1'b0;
      end
      rv[1] = 1'b0;
      chk("b2b_ready", 32'(rp), 32'b10100);
      chk("b2b_resp", 32'(sp), 32'b01010);
      chk("b2b_we", 32'(wp), 32'b01000);
      chk("b2b_lw", rd, 32'hA5A555EF);
      v = '{0, 2'b10, 0, 32'h8, 32'h0,
            32'h0, 0, 2, 1, 0, 32'h0};
      do_req(1, v, "b2b_chk", rd, er, lat, nwe, nresp, wd, wa);
      chk("b2b_sw_data", rd, 32'h11223344);

      // Reset while the sb 0x004 is in WAIT.
      @(negedge clk);
      v = '{1, 2'b00, 0, 32'h4, 32'h00000077,
            32'h0, 0, 3, 2, 1, 32'h0};
      drive(1, v);
      rv[1] = 1'b1;
      @(posedge clk);
      #1 rv[1] = 1'b0;
      nwe = 0; nresp = 0;
      for (int k = 1; k <= 2; k++) begin
         @(negedge clk);
         if (mwe[1]) nwe++;
         if (rsv[1]) nresp++;
      end
      rst_n = 1'b0;
      #1;
      chk("mid_rst_we", 32'(mwe[1]), 32'd0);
      chk("mid_rst_resp", 32'(rsv[1]), 32'd0);
      chk("mid_rst_ready", 32'(rdy[1]), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (mwe[1]) nwe++;
         if (rsv[1]) nresp++;
      end
      chk("mid_rst_nwe", 32'(nwe), 32'd0);
      chk("mid_rst_nresp", 32'(nresp), 32'd0);
      chk("mid_rst_ready2", 32'(rdy[1]), 32'd1);
      v = tbl[1];
      do_req(1, v, "mid_rst_lw", rd, er, lat, nwe, nresp, wd, wa);
      chk("mid_rst_word", rd, 32'hA5A555EF);
      chk("mid_rst_lw_lat", 32'(lat), 32'd2);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
